cpu_branch_unit: RTL and testbench
==================================

CPU_BRANCH_UNIT -- requirements
Module: cpu_branch_unit

Interface
REQ-001 Parameter PC_W, default 8: program counter width in bits.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address stack entries; power of two, minimum 2.
REQ-003 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port RST, input, 1: synchronous, active-low reset, sampled on the CLK rising edge.
REQ-005 Port EN, input, 1: instruction-step enable; when low, all state holds.
REQ-006 Port OP, input, 3: branch operation code (REQ-012).
REQ-007 Port TARGET, input, PC_W: absolute jump or call destination.
REQ-008 Ports C, Z and B, inputs, 1 each: carry, zero and borrow flags from the flag register, consumed as presented at the edge.
REQ-009 Port PC, output, PC_W: registered program counter.
REQ-010 Port TAKEN, output, 1: registered; high for exactly the cycle following an edge that performed a redirect (jump, call or return).
REQ-011 Ports SP (output, clog2(STACK_DEPTH)+1: stack occupancy), STK_OVF (output, 1: sticky overflow) and STK_UNF (output, 1: sticky underflow).

Function
REQ-012 The OP encoding SHALL be:
- 000 NOP
- 001 JMP
- 010 JZ (Z=1)
- 011 JNZ (Z=0)
- 100 JC (C=1)
- 101 JB (B=1)
- 110 CALL
- 111 RET
REQ-013 On an edge with RST high and EN high, the unit SHALL evaluate OP using C, Z and B sampled at that same edge; the PC update therefore has one-cycle latency and no pipeline bubble.
REQ-014 For a NOP or a not-taken conditional, the unit SHALL set PC to PC+1 modulo 2^PC_W and drive TAKEN low; on wrap-around, all-ones steps to 0 with no error.
REQ-015 For JMP, or a conditional whose condition is true, the unit SHALL set PC to TARGET and drive TAKEN high next cycle.
REQ-016 For CALL with SP < STACK_DEPTH, the unit SHALL:
- write PC+1 (wrapped) to stack[SP];
- increment SP;
- set PC to TARGET;
- drive TAKEN high.
REQ-017 For CALL with SP = STACK_DEPTH, the unit SHALL:
- not push;
- set PC to PC+1;
- set STK_OVF;
- drive TAKEN low.
REQ-018 For RET with SP > 0, the unit SHALL:
- decrement SP;
- set PC to stack[SP-1];
- drive TAKEN high.
REQ-019 For RET with SP = 0, the unit SHALL:
- set PC to PC+1;
- set STK_UNF;
- leave SP at 0;
- drive TAKEN low.
REQ-020 STK_OVF and STK_UNF SHALL remain set until reset; they do not block further operations.
REQ-021 With EN low, PC, SP, the stack contents and the sticky flags SHALL hold, and TAKEN SHALL be driven low.
REQ-022 A TARGET equal to PC SHALL be a legal self-jump: PC is unchanged and TAKEN goes high.
REQ-023 Flag inputs SHALL be ignored for NOP, JMP, CALL and RET.
REQ-024 The stack SHALL be LIFO; contents of entries at or above SP are don't-care and SHALL never appear on PC.

Reset
REQ-025 On an edge with RST low, the unit SHALL set PC=0, SP=0, TAKEN=0, STK_OVF=0 and STK_UNF=0, regardless of EN or OP.
REQ-026 Reset SHALL take priority over any in-flight CALL or RET on the same edge; that operation is discarded entirely.
REQ-027 Stack entry contents need not be cleared by reset.

Verification
REQ-028 Reset, then 3 edges of NOP with EN=1 -> PC=3, TAKEN=0 throughout, SP=0.
REQ-029 PC=0x10, JZ TARGET=0x40:
- Z=0 -> PC=0x11, TAKEN=0;
- then Z=1 -> PC=0x40, TAKEN=1 for exactly one cycle.
REQ-030 Nested calls, PC=0x05:
- CALL 0x20 -> PC=0x20, SP=1;
- CALL 0x30 -> PC=0x30, SP=2;
- RET -> PC=0x21, SP=1;
- RET -> PC=0x06, SP=0.
REQ-031 Overflow then underflow:
- 5 consecutive CALLs, STACK_DEPTH=4 -> fifth leaves SP=4, PC=prior+1, STK_OVF=1;
- then 5 RETs -> fifth sets STK_UNF=1, SP=0.
REQ-032 Wrap and hold:
- PC=0xFF, NOP -> PC=0x00;
- EN=0 with OP=JMP -> PC holds, TAKEN=0.
REQ-033 RST driven low on the same edge as CALL with SP=2 -> PC=0, SP=0, TAKEN=0, no push.

Source files
------------

// File: rtl/cpu_branch_unit.sv
// Branch unit: registered program counter with conditional jumps and a small
// return-address stack. Stack overflow/underflow are reported through sticky
// flags and degrade the offending CALL/RET into a plain PC increment.
module cpu_branch_unit #(
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           EN,
   input  logic [2:0]                     OP,
   input  logic [PC_W-1:0]                TARGET,
   input  logic                           C,
   input  logic                           Z,
   input  logic                           B,
   output logic [PC_W-1:0]                PC,
   output logic                           TAKEN,
   output logic [$clog2(STACK_DEPTH):0]   SP,
   output logic                           STK_OVF,
   output logic                           STK_UNF
);

   localparam int SP_W = $clog2(STACK_DEPTH) + 1;
   localparam int IX_W = SP_W - 1;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_JZ   = 3'b010;
   localparam logic [2:0] OP_JNZ  = 3'b011;
   localparam logic [2:0] OP_JC   = 3'b100;
   localparam logic [2:0] OP_JB   = 3'b101;
   localparam logic [2:0] OP_CALL = 3'b110;
   localparam logic [2:0] OP_RET  = 3'b111;

   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0] SP_ONE  = {{(SP_W-1){1'b0}}, 1'b1};
   localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

   logic [PC_W-1:0] stack [STACK_DEPTH];

   logic [PC_W-1:0] pc_inc;
   logic [SP_W-1:0] sp_dec;
   logic [PC_W-1:0] pc_nxt;
   logic [SP_W-1:0] sp_nxt;
   logic            taken_nxt;
   logic            ovf_nxt;
   logic            unf_nxt;
   logic            push;

   assign pc_inc = PC + PC_ONE;
   assign sp_dec = SP - SP_ONE;

   // Decode the operation for this step; default is sequential fetch.
   always_comb begin
      pc_nxt    = pc_inc;
      sp_nxt    = SP;
      taken_nxt = 1'b0;
      ovf_nxt   = STK_OVF;
      unf_nxt   = STK_UNF;
      push      = 1'b0;
      case (OP)
         OP_NOP: ;
         OP_JMP: begin
            pc_nxt    = TARGET;
            taken_nxt = 1'b1;
         end
         OP_JZ, OP_JNZ, OP_JC, OP_JB: begin
            if ((OP == OP_JZ  &&  Z) ||
                (OP == OP_JNZ && !Z) ||
                (OP == OP_JC  &&  C) ||
                (OP == OP_JB  &&  B)) begin
               pc_nxt    = TARGET;
               taken_nxt = 1'b1;
            end
         end
         OP_CALL: begin
            if (SP < SP_FULL) begin
               push      = 1'b1;
               sp_nxt    = SP + SP_ONE;
               pc_nxt    = TARGET;
               taken_nxt = 1'b1;
            end else begin
               ovf_nxt = 1'b1;
            end
         end
         OP_RET: begin
            if (SP != '0) begin
               sp_nxt    = sp_dec;
               pc_nxt    = stack[sp_dec[IX_W-1:0]];
               taken_nxt = 1'b1;
            end else begin
               unf_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Architectural state; reset wins over any operation on the same edge.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         PC      <= '0;
         SP      <= '0;
         TAKEN   <= 1'b0;
         STK_OVF <= 1'b0;
         STK_UNF <= 1'b0;
      end else if (EN) begin
         PC      <= pc_nxt;
         SP      <= sp_nxt;
         TAKEN   <= taken_nxt;
         STK_OVF <= ovf_nxt;
         STK_UNF <= unf_nxt;
      end else begin
         TAKEN   <= 1'b0;
      end
   end

   // Return-address storage; not cleared by reset, only live entries are read.
   always_ff @(posedge CLK) begin
      if (RST && EN && push) begin
         stack[SP[IX_W-1:0]] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_cpu_branch_unit.sv
// Directed bench for cpu_branch_unit with hand-computed expected values.
module tb_cpu_branch_unit;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_JZ   = 3'b010;
   localparam logic [2:0] OP_JNZ  = 3'b011;
   localparam logic [2:0] OP_JC   = 3'b100;
   localparam logic [2:0] OP_JB   = 3'b101;
   localparam logic [2:0] OP_CALL = 3'b110;
   localparam logic [2:0] OP_RET  = 3'b111;

   logic       CLK;
   logic       RST;
   logic       EN;
   logic [2:0] OP;
   logic [7:0] TARGET;
   logic       C;
   logic       Z;
   logic       B;
   logic [7:0] PC;
   logic       TAKEN;
   logic [2:0] SP;
   logic       STK_OVF;
   logic       STK_UNF;

   int n_checks = 0;
   int n_pass   = 0;

   cpu_branch_unit #(.PC_W(8), .STACK_DEPTH(4)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .EN      (EN),
      .OP      (OP),
      .TARGET  (TARGET),
      .C       (C),
      .Z       (Z),
      .B       (B),
      .PC      (PC),
      .TAKEN   (TAKEN),
      .SP      (SP),
      .STK_OVF (STK_OVF),
      .STK_UNF (STK_UNF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One clock edge with the given inputs; returns on the following falling edge.
   task automatic step(input logic rst, input logic en, input logic [2:0] op,
                       input logic [7:0] tgt, input logic c, input logic z, input logic b);
      RST = rst; EN = en; OP = op; TARGET = tgt; C = c; Z = z; B = b;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic op1(input logic [2:0] op, input logic [7:0] tgt, input logic c,
                      input logic z, input logic b);
      step(1'b1, 1'b1, op, tgt, c, z, b);
   endtask

   task automatic expect_core(input string tag, input logic [7:0] pc,
                              input logic [2:0] sp, input logic taken);
      check({tag, ".pc"},    32'(PC),    32'(pc));
      check({tag, ".sp"},    32'(SP),    32'(sp));
      check({tag, ".taken"}, 32'(TAKEN), 32'(taken));
   endtask

   task automatic expect_flags(input string tag, input logic ovf, input logic unf);
      check({tag, ".ovf"}, 32'(STK_OVF), 32'(ovf));
      check({tag, ".unf"}, 32'(STK_UNF), 32'(unf));
   endtask

   initial begin
      RST = 1'b0; EN = 1'b0; OP = OP_NOP; TARGET = 8'h00; C = 1'b0; Z = 1'b0; B = 1'b0;
      @(negedge CLK);

      // reset
      step(1'b0, 1'b1, OP_JMP, 8'hAA, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, OP_CALL, 8'hAA, 1'b0, 1'b0, 1'b0);
      expect_core("reset", 8'h00, 3'd0, 1'b0);
      expect_flags("reset", 1'b0, 1'b0);

      // three NOPs; flags present but ignored
      op1(OP_NOP, 8'h77, 1'b0, 1'b0, 1'b0); expect_core("nop1", 8'h01, 3'd0, 1'b0);
      op1(OP_NOP, 8'h77, 1'b1, 1'b1, 1'b1); expect_core("nop2", 8'h02, 3'd0, 1'b0);
      op1(OP_NOP, 8'h77, 1'b0, 1'b1, 1'b0); expect_core("nop3", 8'h03, 3'd0, 1'b0);

      // conditional branches
      op1(OP_JMP, 8'h10, 1'b0, 1'b0, 1'b0); expect_core("jmp10", 8'h10, 3'd0, 1'b1);
      op1(OP_JZ,  8'h40, 1'b0, 1'b0, 1'b0); expect_core("jz_nt", 8'h11, 3'd0, 1'b0);
      op1(OP_JZ,  8'h40, 1'b0, 1'b1, 1'b0); expect_core("jz_t",  8'h40, 3'd0, 1'b1);
      op1(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("jz_after", 8'h41, 3'd0, 1'b0);
      op1(OP_JNZ, 8'h60, 1'b0, 1'b1, 1'b0); expect_core("jnz_nt", 8'h42, 3'd0, 1'b0);
      op1(OP_JNZ, 8'h60, 1'b0, 1'b0, 1'b0); expect_core("jnz_t",  8'h60, 3'd0, 1'b1);
      op1(OP_JC,  8'h70, 1'b0, 1'b1, 1'b1); expect_core("jc_nt",  8'h61, 3'd0, 1'b0);
      op1(OP_JC,  8'h70, 1'b1, 1'b0, 1'b0); expect_core("jc_t",   8'h70, 3'd0, 1'b1);
      op1(OP_JB,  8'h7A, 1'b1, 1'b1, 1'b0); expect_core("jb_nt",  8'h71, 3'd0, 1'b0);
      op1(OP_JB,  8'h7A, 1'b0, 1'b0, 1'b1); expect_core("jb_t",   8'h7A, 3'd0, 1'b1);

      // nested calls
      op1(OP_JMP,  8'h05, 1'b0, 1'b0, 1'b0); expect_core("to05", 8'h05, 3'd0, 1'b1);
      op1(OP_CALL, 8'h20, 1'b0, 1'b1, 1'b0); expect_core("call20", 8'h20, 3'd1, 1'b1);
      op1(OP_CALL, 8'h30, 1'b1, 1'b0, 1'b1); expect_core("call30", 8'h30, 3'd2, 1'b1);
      op1(OP_RET,  8'hEE, 1'b0, 1'b1, 1'b0); expect_core("ret1", 8'h21, 3'd1, 1'b1);
      op1(OP_RET,  8'hEE, 1'b0, 1'b0, 1'b0); expect_core("ret2", 8'h06, 3'd0, 1'b1);
      expect_flags("nest", 1'b0, 1'b0);

      // overflow then underflow
      op1(OP_CALL, 8'h50, 1'b0, 1'b0, 1'b0); expect_core("oc1", 8'h50, 3'd1, 1'b1);
      op1(OP_CALL, 8'h60, 1'b0, 1'b0, 1'b0); expect_core("oc2", 8'h60, 3'd2, 1'b1);
      op1(OP_CALL, 8'h70, 1'b0, 1'b0, 1'b0); expect_core("oc3", 8'h70, 3'd3, 1'b1);
      op1(OP_CALL, 8'h80, 1'b0, 1'b0, 1'b0); expect_core("oc4", 8'h80, 3'd4, 1'b1);
      expect_flags("oc4", 1'b0, 1'b0);
      op1(OP_CALL, 8'h90, 1'b0, 1'b0, 1'b0); expect_core("oc5", 8'h81, 3'd4, 1'b0);
      expect_flags("oc5", 1'b1, 1'b0);
      op1(OP_RET, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("ur1", 8'h71, 3'd3, 1'b1);
      op1(OP_RET, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("ur2", 8'h61, 3'd2, 1'b1);
      op1(OP_RET, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("ur3", 8'h51, 3'd1, 1'b1);
      op1(OP_RET, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("ur4", 8'h07, 3'd0, 1'b1);
      expect_flags("ur4", 1'b1, 1'b0);
      op1(OP_RET, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("ur5", 8'h08, 3'd0, 1'b0);
      expect_flags("ur5", 1'b1, 1'b1);
      op1(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("sticky", 8'h09, 3'd0, 1'b0);
      expect_flags("sticky", 1'b1, 1'b1);

      // self-jump
      op1(OP_JMP, 8'h09, 1'b0, 1'b0, 1'b0); expect_core("self", 8'h09, 3'd0, 1'b1);

      // wrap and hold
      op1(OP_JMP, 8'hFF, 1'b0, 1'b0, 1'b0); expect_core("toFF", 8'hFF, 3'd0, 1'b1);
      op1(OP_NOP, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("wrap", 8'h00, 3'd0, 1'b0);
      op1(OP_JMP, 8'h12, 1'b0, 1'b0, 1'b0); expect_core("to12", 8'h12, 3'd0, 1'b1);
      step(1'b1, 1'b0, OP_JMP, 8'h33, 1'b0, 1'b0, 1'b0);
      expect_core("hold_jmp", 8'h12, 3'd0, 1'b0);
      step(1'b1, 1'b0, OP_CALL, 8'h44, 1'b0, 1'b0, 1'b0);
      expect_core("hold_call", 8'h12, 3'd0, 1'b0);
      expect_flags("hold", 1'b1, 1'b1);

      // reset beats CALL with two entries live
      op1(OP_CALL, 8'h20, 1'b0, 1'b0, 1'b0); expect_core("rc1", 8'h20, 3'd1, 1'b1);
      op1(OP_CALL, 8'h30, 1'b0, 1'b0, 1'b0); expect_core("rc2", 8'h30, 3'd2, 1'b1);
      step(1'b0, 1'b1, OP_CALL, 8'h40, 1'b0, 1'b0, 1'b0);
      expect_core("rst_call", 8'h00, 3'd0, 1'b0);
      expect_flags("rst_call", 1'b0, 1'b0);
      op1(OP_RET, 8'h00, 1'b0, 1'b0, 1'b0); expect_core("post_rst_ret", 8'h01, 3'd0, 1'b0);
      expect_flags("post_rst_ret", 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
